// File: rtl/exp_sched_pkg.sv
// Shared types and widths for the exponential-engine scheduler.
// Operand and result widths are fixed by the engine interface.
package exp_sched_pkg;

    localparam int unsigned X_W   = 16;
    localparam int unsigned INT_W = 2;

    typedef enum logic [2:0] {
        StIdle,
        StEngRst,
        StStart,
        StWait,
        StResp
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_ptr, wrapping.
// The pointer register is owned by the instantiating block.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic             o_gnt_any,
    output logic [ID_W-1:0]  o_gnt_id
);

    logic [2*N_REQ-1:0] w_rot;
    logic [ID_W:0]      w_sum;

    always_comb begin
        // Rotate so bit 0 is the requester at the pointer; lowest set bit wins.
        w_rot     = {i_req, i_req} >> i_ptr;
        o_gnt_any = 1'b0;
        w_sum     = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                o_gnt_any = 1'b1;
                w_sum     = {1'b0, i_ptr} + (ID_W+1)'(i);
            end
        end
        if (w_sum >= (ID_W+1)'(N_REQ)) begin
            w_sum = w_sum - (ID_W+1)'(N_REQ);
        end
        o_gnt_id = w_sum[ID_W-1:0];
    end

endmodule

// File: rtl/exp_engine_scheduler.sv
// Shares one exponential engine among N_REQ requesters: round-robin grant, engine reset and
// start sequencing, timeout-guarded wait for done, and an id-tagged registered response.
module exp_engine_scheduler
    import exp_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req_valid,
    input  logic [N_REQ*X_W-1:0]   i_req_x,
    output logic [N_REQ-1:0]       o_req_ready,
    output logic                   o_eng_rst,
    output logic                   o_eng_start,
    output logic [X_W-1:0]         o_eng_x,
    input  logic                   i_eng_done,
    input  logic [INT_W-1:0]       i_eng_intpart,
    input  logic [X_W-1:0]         i_eng_fracpart,
    output logic                   o_resp_valid,
    output logic [ID_W-1:0]        o_resp_id,
    output logic [INT_W-1:0]       o_resp_intpart,
    output logic [X_W-1:0]         o_resp_fracpart,
    output logic                   o_resp_err,
    output logic                   o_busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    sched_state_e       r_state, w_state_d;
    logic [ID_W-1:0]    r_ptr, w_ptr_d;
    logic [ID_W-1:0]    r_id, w_id_d;
    logic [X_W-1:0]     r_x, w_x_d;
    logic [CNT_W-1:0]   r_cnt, w_cnt_d;
    logic [INT_W-1:0]   r_res_int, w_res_int_d;
    logic [X_W-1:0]     r_res_frac, w_res_frac_d;
    logic               r_res_err, w_res_err_d;
    logic [N_REQ-1:0]   r_req_ready, w_req_ready_d;
    logic               r_eng_rst;
    logic               r_eng_start;
    logic               r_resp_valid;
    logic               r_busy;

    logic               w_gnt_any;
    logic [ID_W-1:0]    w_gnt_id;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .i_req     (i_req_valid),
        .i_ptr     (r_ptr),
        .o_gnt_any (w_gnt_any),
        .o_gnt_id  (w_gnt_id)
    );

    always_comb begin
        w_state_d     = r_state;
        w_ptr_d       = r_ptr;
        w_id_d        = r_id;
        w_x_d         = r_x;
        w_cnt_d       = r_cnt;
        w_res_int_d   = r_res_int;
        w_res_frac_d  = r_res_frac;
        w_res_err_d   = r_res_err;
        w_req_ready_d = '0;

        unique case (r_state)
            StIdle: begin
                if (w_gnt_any) begin
                    w_state_d = StEngRst;
                    w_id_d    = w_gnt_id;
                    for (int i = 0; i < int'(N_REQ); i++) begin
                        if (w_gnt_id == ID_W'(i)) begin
                            w_x_d            = i_req_x[i*X_W +: X_W];
                            w_req_ready_d[i] = 1'b1;
                        end
                    end
                    w_ptr_d = (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
                end
            end
            StEngRst: begin
                w_state_d = StStart;
            end
            StStart: begin
                w_state_d = StWait;
                w_cnt_d   = '0;
            end
            StWait: begin
                w_cnt_d = r_cnt + CNT_W'(1);
                // Done takes priority over a timeout in the same cycle.
                if (i_eng_done) begin
                    w_state_d    = StResp;
                    w_res_int_d  = i_eng_intpart;
                    w_res_frac_d = i_eng_fracpart;
                    w_res_err_d  = 1'b0;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_d    = StResp;
                    w_res_int_d  = '0;
                    w_res_frac_d = '0;
                    w_res_err_d  = 1'b1;
                end
            end
            StResp: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Strobe outputs are decoded from the next state so they line up with the state itself.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_ptr        <= '0;
            r_id         <= '0;
            r_x          <= '0;
            r_cnt        <= '0;
            r_res_int    <= '0;
            r_res_frac   <= '0;
            r_res_err    <= 1'b0;
            r_req_ready  <= '0;
            r_eng_rst    <= 1'b1;
            r_eng_start  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_ptr        <= w_ptr_d;
            r_id         <= w_id_d;
            r_x          <= w_x_d;
            r_cnt        <= w_cnt_d;
            r_res_int    <= w_res_int_d;
            r_res_frac   <= w_res_frac_d;
            r_res_err    <= w_res_err_d;
            r_req_ready  <= w_req_ready_d;
            r_eng_rst    <= (w_state_d == StEngRst);
            r_eng_start  <= (w_state_d == StStart);
            r_resp_valid <= (w_state_d == StResp);
            r_busy       <= (w_state_d != StIdle);
        end
    end

    assign o_req_ready     = r_req_ready;
    assign o_eng_rst       = r_eng_rst;
    assign o_eng_start     = r_eng_start;
    assign o_eng_x         = r_x;
    assign o_resp_valid    = r_resp_valid;
    assign o_resp_id       = r_id;
    assign o_resp_intpart  = r_res_int;
    assign o_resp_fracpart = r_res_frac;
    assign o_resp_err      = r_res_err;
    assign o_busy          = r_busy;

endmodule
